// File: rtl/fir_trans_param.sv
`default_nettype none
// ============================================================================
// Module      : fir_trans_param
// Description : Parametrised transposed-form FIR filter with double-buffered
//               run-time coefficients, sample-valid handshake, round-half-up
//               output scaling, saturation flag and delay-line flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_trans_param #(
  parameter int IN_WL   = 15,
  parameter int COEF_WL = 15,
  parameter int OUT_WL  = 20,
  parameter int TAPS    = 16,
  parameter int SHIFT   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [IN_WL-1:0]     data_in,
  input  logic                        coef_we,
  input  logic [$clog2(TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_WL-1:0]   coef_data,
  input  logic                        coef_swap,
  input  logic                        flush,
  output logic                        out_valid,
  output logic signed [OUT_WL-1:0]    data_out,
  output logic                        sat_flag
);

  localparam int AW      = $clog2(TAPS);
  localparam int PROD_WL = IN_WL + COEF_WL;
  localparam int ACC_WL  = PROD_WL + AW;
  // One guard bit so the rounding offset can never wrap the accumulator.
  localparam int RW      = ACC_WL + 1;

  localparam logic signed [OUT_WL-1:0] OUT_MAX = {1'b0, {(OUT_WL-1){1'b1}}};
  localparam logic signed [OUT_WL-1:0] OUT_MIN = {1'b1, {(OUT_WL-1){1'b0}}};

  logic signed [COEF_WL-1:0] shadow [TAPS];
  logic signed [COEF_WL-1:0] active [TAPS];
  logic signed [PROD_WL-1:0] prod   [TAPS];
  logic signed [ACC_WL-1:0]  z      [1:TAPS-1];
  logic signed [ACC_WL-1:0]  zeff   [1:TAPS-1];
  logic signed [ACC_WL-1:0]  y;
  logic signed [RW-1:0]      r;
  logic                      addr_ok;
  logic                      fits;
  logic signed [OUT_WL-1:0]  sat_val;

  // Addresses beyond the last tap are dropped rather than aliased.
  generate
    if (TAPS == (1 << AW)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_chk
      localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
      assign addr_ok = (coef_addr <= LAST);
    end
  endgenerate

  // Shadow/active coefficient banks; swap copies the pre-write shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (coef_swap) begin
        for (int k = 0; k < TAPS; k++) active[k] <= shadow[k];
      end
      if (coef_we && addr_ok) shadow[coef_addr] <= coef_data;
    end
  end

  // Full-precision products of the current sample with every active tap.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = $signed({{IN_WL{active[k][COEF_WL-1]}}, active[k]})
              * $signed({{COEF_WL{data_in[IN_WL-1]}}, data_in});
    end
  end

  // Delay-line view seen by this sample: a flush makes it read as zero.
  always_comb begin
    for (int k = 1; k < TAPS; k++) zeff[k] = flush ? '0 : z[k];
    y = $signed({{AW{prod[0][PROD_WL-1]}}, prod[0]}) + zeff[1];
  end

  // Transposed delay line: advances only on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k < TAPS; k++) z[k] <= '0;
    end else if (in_valid) begin
      for (int k = 1; k < TAPS - 1; k++) begin
        z[k] <= $signed({{AW{prod[k][PROD_WL-1]}}, prod[k]}) + zeff[k+1];
      end
      z[TAPS-1] <= $signed({{AW{prod[TAPS-1][PROD_WL-1]}}, prod[TAPS-1]});
    end else if (flush) begin
      for (int k = 1; k < TAPS; k++) z[k] <= '0;
    end
  end

  // Round half toward +inf, then arithmetic right shift.
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RW-1:0] HALF = RW'(64'd1 << (SHIFT - 1));
      logic signed [RW-1:0] y_rnd;
      assign y_rnd = $signed({y[ACC_WL-1], y}) + HALF;
      assign r     = y_rnd >>> SHIFT;
    end else begin : g_noround
      assign r = $signed({y[ACC_WL-1], y});
    end
  endgenerate

  // Value fits when all bits above the output sign bit agree with it.
  always_comb begin
    fits    = (&r[RW-1:OUT_WL-1]) | ~(|r[RW-1:OUT_WL-1]);
    sat_val = fits ? r[OUT_WL-1:0] : (r[RW-1] ? OUT_MIN : OUT_MAX);
  end

  // Registered outputs; data and flag hold between valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out <= sat_val;
        sat_flag <= ~fits;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_trans_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_trans_param
// Description : Directed scoreboard bench for fir_trans_param (TAPS=4, with
//               an unscaled instance and a SHIFT=2 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_trans_param;

  typedef struct {
    logic signed [19:0] d;
    logic               s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  // unscaled instance
  logic               in_valid, coef_we, coef_swap, flush;
  logic signed [14:0] data_in, coef_data;
  logic [1:0]         coef_addr;
  logic               out_valid, sat_flag;
  logic signed [19:0] data_out;
  // SHIFT=2 instance
  logic               b_in_valid, b_coef_we, b_coef_swap, b_flush;
  logic signed [14:0] b_data_in, b_coef_data;
  logic [1:0]         b_coef_addr;
  logic               b_out_valid, b_sat_flag;
  logic signed [19:0] b_data_out;

  int vectors     = 0;
  int miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic exp_ov0 = 1'b0;
  logic exp_ov1 = 1'b0;

  fir_trans_param #(.IN_WL(15), .COEF_WL(15), .OUT_WL(20), .TAPS(4), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_swap(coef_swap), .flush(flush), .out_valid(out_valid),
    .data_out(data_out), .sat_flag(sat_flag));

  fir_trans_param #(.IN_WL(15), .COEF_WL(15), .OUT_WL(20), .TAPS(4), .SHIFT(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .data_in(b_data_in),
    .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
    .coef_swap(b_coef_swap), .flush(b_flush), .out_valid(b_out_valid),
    .data_out(b_data_out), .sat_flag(b_sat_flag));

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // out_valid model: previous cycle's in_valid, forced low by reset.
  always @(posedge clk) begin
    exp_ov0 <= rst ? 1'b0 : in_valid;
    exp_ov1 <= rst ? 1'b0 : b_in_valid;
  end

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    chk("out_valid0", {31'd0, out_valid}, {31'd0, exp_ov0});
    if (out_valid === 1'b1) begin
      vectors++;
      assert (q0.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected0: observed data %0d expected no output", data_out);
      end
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("data0", data_out, e.d);
        chk("sat0", {31'd0, sat_flag}, {31'd0, e.s});
      end
    end
    chk("out_valid1", {31'd0, b_out_valid}, {31'd0, exp_ov1});
    if (b_out_valid === 1'b1) begin
      vectors++;
      assert (q1.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected1: observed data %0d expected no output", b_data_out);
      end
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("data1", b_data_out, e.d);
        chk("sat1", {31'd0, b_sat_flag}, {31'd0, e.s});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;   coef_we = 1'b0;   coef_swap = 1'b0;   flush = 1'b0;
    b_in_valid = 1'b0; b_coef_we = 1'b0; b_coef_swap = 1'b0; b_flush = 1'b0;
  endtask

  task automatic smp(input int x, input int e, input bit s);
    exp_t t;
    t.d = 20'(e); t.s = s;
    q0.push_back(t);
    in_valid = 1'b1; data_in = 15'(x);
    tick();
  endtask

  task automatic load4(input int c0, input int c1, input int c2, input int c3);
    int c[4];
    c = '{c0, c1, c2, c3};
    for (int k = 0; k < 4; k++) begin
      coef_we = 1'b1; coef_addr = 2'(k); coef_data = 15'(c[k]);
      tick();
    end
    coef_swap = 1'b1;
    tick();
  endtask

  task automatic b_smp(input int x, input int e, input bit s);
    exp_t t;
    t.d = 20'(e); t.s = s;
    q1.push_back(t);
    b_in_valid = 1'b1; b_data_in = 15'(x);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; coef_we = 0; coef_swap = 0; flush = 0;
    data_in = '0; coef_addr = '0; coef_data = '0;
    b_in_valid = 0; b_coef_we = 0; b_coef_swap = 0; b_flush = 0;
    b_data_in = '0; b_coef_addr = '0; b_coef_data = '0;
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'sd0);
    chk("rst_data_out", data_out, 32'sd0);
    chk("rst_sat_flag", {31'd0, sat_flag}, 32'sd0);
    chk("rst_data_out1", b_data_out, 32'sd0);

    // impulse
    load4(1, 2, 3, 4);
    smp(100, 100, 0); smp(0, 200, 0); smp(0, 300, 0); smp(0, 400, 0); smp(0, 0, 0);

    // gapped impulse
    begin
      int xs[5];
      int es[5];
      xs = '{100, 0, 0, 0, 0};
      es = '{100, 200, 300, 400, 0};
      for (int i = 0; i < 5; i++) begin
        smp(xs[i], es[i], 0);
        repeat (3) tick();
      end
    end

    // saturation, both rails
    load4(16383, 16383, 16383, 16383);
    repeat (4) smp(16383, 524287, 1);
    flush = 1'b1; tick();
    repeat (4) smp(-16384, -524288, 1);
    flush = 1'b1; tick();

    // rounding on the SHIFT=2 instance
    for (int k = 0; k < 4; k++) begin
      b_coef_we = 1'b1; b_coef_addr = 2'(k); b_coef_data = (k == 0) ? 15'sd1 : 15'sd0;
      tick();
    end
    b_coef_swap = 1'b1; tick();
    b_smp(6, 2, 0); b_smp(-6, -1, 0); b_smp(5, 1, 0); b_smp(-5, -1, 0);

    // swap and flush
    load4(1, 1, 1, 1);
    smp(10, 10, 0); smp(10, 20, 0); smp(10, 30, 0); smp(10, 40, 0);
    for (int k = 0; k < 4; k++) begin
      coef_we = 1'b1; coef_addr = 2'(k); coef_data = 15'sd2;
      tick();
    end
    coef_swap = 1'b1;
    smp(10, 40, 0); smp(10, 50, 0); smp(10, 60, 0); smp(10, 70, 0); smp(10, 80, 0);
    flush = 1'b1;
    smp(10, 20, 0); smp(10, 40, 0); smp(10, 60, 0); smp(10, 80, 0);

    // write and swap in the same cycle: swap sees the pre-write shadow
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 15'sd5; coef_swap = 1'b1;
    tick();
    flush = 1'b1; smp(1, 2, 0);
    coef_swap = 1'b1; tick();
    flush = 1'b1; smp(1, 5, 0);

    // reset mid-stream
    flush = 1'b1; tick();
    load4(1, 2, 3, 4);
    smp(100, 100, 0); smp(0, 200, 0);
    rst = 1'b1; in_valid = 1'b1; data_in = '0;
    tick();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'sd0);
    chk("midrst_data_out", data_out, 32'sd0);
    smp(100, 0, 0); smp(0, 0, 0);
    load4(1, 2, 3, 4);
    smp(100, 100, 0); smp(0, 200, 0);

    repeat (3) tick();
    chk("drain0", q0.size(), 32'sd0);
    chk("drain1", q1.size(), 32'sd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
